// File: rtl/irq_sequencer_if.sv
// Bus bundle for irq_sequencer.
//   master : request/config/CPU-side drivers (irq_in, mask/ie/vector writes,
//            instr_done, pc_cur, rti); observes PC redirect and status.
//   slave  : the sequencer; drives pc_load/pc_next and status outputs.
interface irq_sequencer_if #(
    parameter int AW = 8
);
    logic [3:0]    irq_in;
    logic          mask_wr;
    logic [3:0]    mask_data;
    logic          ie_set;
    logic          ie_clr;
    logic          vec_we;
    logic [1:0]    vec_sel;
    logic [AW-1:0] vec_data;
    logic          instr_done;
    logic [AW-1:0] pc_cur;
    logic          rti;
    logic          pc_load;
    logic [AW-1:0] pc_next;
    logic          i_pending;
    logic          isr_active;
    logic [1:0]    isr_id;
    logic [3:0]    mask_q;
    logic          ie_q;

    modport master (
        output irq_in, mask_wr, mask_data, ie_set, ie_clr, vec_we, vec_sel,
               vec_data, instr_done, pc_cur, rti,
        input  pc_load, pc_next, i_pending, isr_active, isr_id, mask_q, ie_q
    );

    modport slave (
        input  irq_in, mask_wr, mask_data, ie_set, ie_clr, vec_we, vec_sel,
               vec_data, instr_done, pc_cur, rti,
        output pc_load, pc_next, i_pending, isr_active, isr_id, mask_q, ie_q
    );
endinterface

// File: rtl/irq_sequencer.sv
// Interrupt sequencer for a 4-source priority interrupt unit (source 3 highest).
// Latches requests, applies mask and global enable, and at an instruction
// boundary saves the return PC, redirects to the ISR vector, blocks nesting
// while the handler runs, and restores the PC on return-from-interrupt.
// Ports:
//   clk  : system clock, rising edge
//   clr  : asynchronous reset, active-high
//   bus  : irq_sequencer_if.slave (requests, config writes, CPU handshake,
//          PC redirect and status outputs)
module irq_sequencer #(
    parameter int            AW   = 8,
    parameter logic [AW-1:0] VEC0 = AW'(8'h11),
    parameter logic [AW-1:0] VEC1 = AW'(8'h33),
    parameter logic [AW-1:0] VEC2 = AW'(8'hF0),
    parameter logic [AW-1:0] VEC3 = AW'(8'hAA)
) (
    input  logic           clk,
    input  logic           clr,
    irq_sequencer_if.slave bus
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_SAVE,
        S_VECTOR,
        S_SERVICE,
        S_RETURN
    } state_t;

    state_t        state_q, state_d;
    logic [3:0]    pend_q;
    logic [3:0]    mask_r;
    logic          ie_r;
    logic [AW-1:0] vectors [4];
    logic [AW-1:0] ret_pc;
    logic [1:0]    isr_id_r;

    logic [3:0]    eff;
    logic [1:0]    winner;
    logic          accept;
    logic [3:0]    pend_clr;
    logic          pc_load_c;
    logic [AW-1:0] pc_next_c;

    // Ascending scan: the last set bit seen is the highest index, i.e. the winner.
    always_comb begin
        eff    = pend_q & mask_r;
        winner = 2'd0;
        for (int unsigned i = 0; i < 4; i++) begin
            if (eff[i]) winner = 2'(i);
        end
    end

    always_comb begin
        state_d   = state_q;
        accept    = 1'b0;
        pc_load_c = 1'b0;
        pc_next_c = '0;
        case (state_q)
            S_IDLE: begin
                if (ie_r && (|eff) && bus.instr_done) begin
                    accept  = 1'b1;
                    state_d = S_SAVE;
                end
            end
            S_SAVE:   state_d = S_VECTOR;
            S_VECTOR: begin
                pc_load_c = 1'b1;
                pc_next_c = vectors[isr_id_r];
                state_d   = S_SERVICE;
            end
            S_SERVICE: begin
                if (bus.rti) state_d = S_RETURN;
            end
            S_RETURN: begin
                pc_load_c = 1'b1;
                pc_next_c = ret_pc;
                state_d   = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign pend_clr = accept ? (4'b0001 << winner) : '0;

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q  <= S_IDLE;
            pend_q   <= '0;
            mask_r   <= '1;
            ie_r     <= 1'b0;
            ret_pc   <= '0;
            isr_id_r <= '0;
        end else begin
            state_q <= state_d;
            // A new request on the bit being accepted survives the clear.
            pend_q  <= (pend_q & ~pend_clr) | bus.irq_in;
            if (bus.mask_wr) mask_r <= bus.mask_data;
            case (state_q)
                S_SAVE:   ie_r <= 1'b0;
                S_RETURN: ie_r <= 1'b1;
                S_IDLE: begin
                    if (bus.ie_clr)      ie_r <= 1'b0;
                    else if (bus.ie_set) ie_r <= 1'b1;
                end
                default: ;
            endcase
            if (accept) begin
                ret_pc   <= bus.pc_cur;
                isr_id_r <= winner;
            end
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            vectors[0] <= VEC0;
            vectors[1] <= VEC1;
            vectors[2] <= VEC2;
            vectors[3] <= VEC3;
        end else if (bus.vec_we) begin
            vectors[bus.vec_sel] <= bus.vec_data;
        end
    end

    assign bus.pc_load    = pc_load_c;
    assign bus.pc_next    = pc_next_c;
    assign bus.i_pending  = |eff;
    assign bus.isr_active = (state_q == S_SERVICE) || (state_q == S_RETURN);
    assign bus.isr_id     = isr_id_r;
    assign bus.mask_q     = mask_r;
    assign bus.ie_q       = ie_r;
endmodule

// File: tb/tb_irq_sequencer.sv
module tb_irq_sequencer;
    logic clk = 1'b0;
    logic clr = 1'b1;

    irq_sequencer_if #(.AW(8)) bus ();

    irq_sequencer #(
        .AW(8), .VEC0(8'h11), .VEC1(8'h33), .VEC2(8'hF0), .VEC3(8'hAA)
    ) dut (
        .clk(clk),
        .clr(clr),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    logic [7:0] sb [$];
    logic [7:0] mon_exp;

    // Scoreboard: every pc_load must match the oldest expected target;
    // pc_next must be zero whenever pc_load is low.
    always @(negedge clk) begin
        if (clr !== 1'b1) begin
            checks++;
            if (bus.pc_load === 1'b1) begin
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_load: pc_load=1 pc_next=%h, required pc_load=0", bus.pc_next);
                end else begin
                    mon_exp = sb.pop_front();
                    if (bus.pc_next !== mon_exp) begin
                        errors++;
                        $display("FAIL load_target: pc_next=%h, required %h", bus.pc_next, mon_exp);
                    end
                end
            end else if (bus.pc_next !== 8'h00) begin
                errors++;
                $display("FAIL pc_next_idle: pc_next=%h, required 00", bus.pc_next);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation still running, required completion");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Full accept -> vector -> service -> rti -> return sequence from IDLE.
    task automatic do_service(input logic [1:0] id, input logic [7:0] vec,
                              input logic [7:0] pc, input logic [3:0] irq_during);
        tick(); bus.instr_done = 1'b1; bus.pc_cur = pc; sb.push_back(vec);
        tick(); bus.instr_done = 1'b0; bus.pc_cur = 8'h00;
        @(negedge clk);
        checks++; if (bus.pc_load !== 1'b0) begin errors++; $display("FAIL save_no_load: pc_load=%b, required 0", bus.pc_load); end
        tick();
        @(negedge clk);
        checks++; if (bus.pc_load !== 1'b1) begin errors++; $display("FAIL vec_latency: pc_load=%b, required 1", bus.pc_load); end
        checks++; if (bus.ie_q !== 1'b0) begin errors++; $display("FAIL vec_ie: ie_q=%b, required 0", bus.ie_q); end
        tick(); bus.irq_in = irq_during;
        @(negedge clk);
        checks++; if (bus.isr_active !== 1'b1) begin errors++; $display("FAIL svc_active: isr_active=%b, required 1", bus.isr_active); end
        checks++; if (bus.isr_id !== id) begin errors++; $display("FAIL svc_id: isr_id=%0d, required %0d", bus.isr_id, id); end
        tick(); bus.irq_in = 4'b0000;
        repeat (2) tick();
        @(negedge clk);
        checks++; if (bus.isr_active !== 1'b1 || bus.pc_load !== 1'b0) begin errors++; $display("FAIL svc_hold: isr_active=%b pc_load=%b, required 1/0", bus.isr_active, bus.pc_load); end
        tick(); bus.rti = 1'b1; sb.push_back(pc);
        tick(); bus.rti = 1'b0;
        @(negedge clk);
        checks++; if (bus.pc_load !== 1'b1) begin errors++; $display("FAIL rti_latency: pc_load=%b, required 1", bus.pc_load); end
        tick();
        @(negedge clk);
        checks++; if (bus.ie_q !== 1'b1) begin errors++; $display("FAIL ret_ie: ie_q=%b, required 1", bus.ie_q); end
        checks++; if (bus.isr_active !== 1'b0) begin errors++; $display("FAIL ret_active: isr_active=%b, required 0", bus.isr_active); end
    endtask

    task automatic test_reset();
        #12;
        checks++; if (bus.mask_q !== 4'hF || bus.ie_q !== 1'b0 || bus.pc_load !== 1'b0 || bus.pc_next !== 8'h00 || bus.i_pending !== 1'b0 || bus.isr_active !== 1'b0 || bus.isr_id !== 2'd0) begin
            errors++; $display("FAIL reset_outputs: mask=%h ie=%b load=%b next=%h pend=%b act=%b id=%0d, required F/0/0/00/0/0/0",
                bus.mask_q, bus.ie_q, bus.pc_load, bus.pc_next, bus.i_pending, bus.isr_active, bus.isr_id);
        end
        tick(); clr = 1'b0;
        @(negedge clk);
        checks++; if (bus.mask_q !== 4'hF || bus.ie_q !== 1'b0) begin errors++; $display("FAIL reset_release: mask=%h ie=%b, required F/0", bus.mask_q, bus.ie_q); end
        tick(); bus.irq_in = 4'b0001;
        tick(); bus.irq_in = 4'b0000; bus.instr_done = 1'b1;
        @(negedge clk);
        checks++; if (bus.i_pending !== 1'b1) begin errors++; $display("FAIL reset_pending: i_pending=%b, required 1", bus.i_pending); end
        repeat (3) tick();
        bus.instr_done = 1'b0;
        @(negedge clk);
        checks++; if (bus.isr_active !== 1'b0 || bus.ie_q !== 1'b0) begin errors++; $display("FAIL ie_off_no_entry: isr_active=%b ie_q=%b, required 0/0", bus.isr_active, bus.ie_q); end
    endtask

    task automatic test_basic();
        tick(); bus.ie_set = 1'b1;
        tick(); bus.ie_set = 1'b0; bus.irq_in = 4'b0010;
        tick(); bus.irq_in = 4'b0000;
        @(negedge clk);
        checks++; if (bus.ie_q !== 1'b1) begin errors++; $display("FAIL basic_ie_set: ie_q=%b, required 1", bus.ie_q); end
        do_service(2'd1, 8'h33, 8'h40, 4'b0000);
    endtask

    task automatic test_priority();
        tick(); bus.irq_in = 4'b1101;
        tick(); bus.irq_in = 4'b0000;
        do_service(2'd3, 8'hAA, 8'h50, 4'b0000);
        @(negedge clk);
        checks++; if (bus.i_pending !== 1'b1) begin errors++; $display("FAIL prio_after3: i_pending=%b, required 1", bus.i_pending); end
        do_service(2'd2, 8'hF0, 8'h52, 4'b0000);
        do_service(2'd0, 8'h11, 8'h54, 4'b0000);
        @(negedge clk);
        checks++; if (bus.i_pending !== 1'b0) begin errors++; $display("FAIL prio_drained: i_pending=%b, required 0", bus.i_pending); end
    endtask

    task automatic test_ie_and_rti();
        tick(); bus.ie_set = 1'b1; bus.ie_clr = 1'b1;
        tick(); bus.ie_set = 1'b0; bus.ie_clr = 1'b0;
        @(negedge clk);
        checks++; if (bus.ie_q !== 1'b0) begin errors++; $display("FAIL ie_clr_wins: ie_q=%b, required 0", bus.ie_q); end
        tick(); bus.ie_set = 1'b1;
        tick(); bus.ie_set = 1'b0; bus.rti = 1'b1;
        tick(); bus.rti = 1'b0;
        @(negedge clk);
        checks++; if (bus.ie_q !== 1'b1 || bus.isr_active !== 1'b0) begin errors++; $display("FAIL rti_idle_ignored: ie_q=%b isr_active=%b, required 1/0", bus.ie_q, bus.isr_active); end
    endtask

    task automatic test_mask();
        tick(); bus.mask_wr = 1'b1; bus.mask_data = 4'b0111;
        tick(); bus.mask_wr = 1'b0; bus.irq_in = 4'b1000;
        tick(); bus.irq_in = 4'b0000;
        @(negedge clk);
        checks++; if (bus.mask_q !== 4'b0111) begin errors++; $display("FAIL mask_write: mask_q=%h, required 7", bus.mask_q); end
        checks++; if (bus.i_pending !== 1'b0) begin errors++; $display("FAIL mask_blocks: i_pending=%b, required 0", bus.i_pending); end
        tick(); bus.instr_done = 1'b1;
        repeat (3) tick();
        bus.instr_done = 1'b0;
        @(negedge clk);
        checks++; if (bus.isr_active !== 1'b0) begin errors++; $display("FAIL mask_no_entry: isr_active=%b, required 0", bus.isr_active); end
        tick(); bus.mask_wr = 1'b1; bus.mask_data = 4'hF;
        tick(); bus.mask_wr = 1'b0;
        @(negedge clk);
        checks++; if (bus.i_pending !== 1'b1) begin errors++; $display("FAIL unmask_pending: i_pending=%b, required 1", bus.i_pending); end
        do_service(2'd3, 8'hAA, 8'h60, 4'b0000);
    endtask

    task automatic test_vector_no_nesting();
        tick(); bus.vec_we = 1'b1; bus.vec_sel = 2'd0; bus.vec_data = 8'h80;
        tick(); bus.vec_we = 1'b0; bus.irq_in = 4'b0001;
        tick(); bus.irq_in = 4'b0000;
        do_service(2'd0, 8'h80, 8'h70, 4'b1000);
        @(negedge clk);
        checks++; if (bus.i_pending !== 1'b1) begin errors++; $display("FAIL nest_latched: i_pending=%b, required 1", bus.i_pending); end
        do_service(2'd3, 8'hAA, 8'h72, 4'b0000);
    endtask

    task automatic test_mid_reset();
        tick(); bus.mask_wr = 1'b1; bus.mask_data = 4'b0101;
        tick(); bus.mask_wr = 1'b0; bus.irq_in = 4'b0100;
        tick(); bus.irq_in = 4'b0000; bus.instr_done = 1'b1; bus.pc_cur = 8'h90;
        tick(); bus.instr_done = 1'b0; bus.pc_cur = 8'h00;
        tick();
        clr = 1'b1;
        #1;
        checks++; if (bus.pc_load !== 1'b0 || bus.pc_next !== 8'h00) begin errors++; $display("FAIL midrst_load: pc_load=%b pc_next=%h, required 0/00", bus.pc_load, bus.pc_next); end
        checks++; if (bus.isr_active !== 1'b0 || bus.i_pending !== 1'b0 || bus.mask_q !== 4'hF || bus.ie_q !== 1'b0) begin
            errors++; $display("FAIL midrst_state: act=%b pend=%b mask=%h ie=%b, required 0/0/F/0", bus.isr_active, bus.i_pending, bus.mask_q, bus.ie_q);
        end
        tick(); clr = 1'b0; bus.ie_set = 1'b1;
        tick(); bus.ie_set = 1'b0; bus.irq_in = 4'b1111;
        tick(); bus.irq_in = 4'b0000;
        do_service(2'd3, 8'hAA, 8'hA0, 4'b0000);
        do_service(2'd2, 8'hF0, 8'hA2, 4'b0000);
        do_service(2'd1, 8'h33, 8'hA4, 4'b0000);
        do_service(2'd0, 8'h11, 8'hA6, 4'b0000);
    endtask

    initial begin
        bus.irq_in = '0; bus.mask_wr = 1'b0; bus.mask_data = '0;
        bus.ie_set = 1'b0; bus.ie_clr = 1'b0; bus.vec_we = 1'b0;
        bus.vec_sel = '0; bus.vec_data = '0; bus.instr_done = 1'b0;
        bus.pc_cur = '0; bus.rti = 1'b0;
        test_reset();
        test_basic();
        test_priority();
        test_ie_and_rti();
        test_mask();
        test_vector_no_nesting();
        test_mid_reset();
        repeat (3) tick();
        checks++; if (sb.size() != 0) begin errors++; $display("FAIL sb_leftover: %0d loads outstanding, required 0", sb.size()); end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
